// File: rtl/dircc_mem_master_pkg.sv
// Shared types and constants for the s2 memory-port initiator.
package dircc_mem_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int         MEM_WORDS_DEFAULT = 15000;
    localparam int         S2_ADDR_W         = 14;
    localparam int         S2_DATA_W         = 16;
    localparam logic [1:0] BE_ALL            = 2'b11;

endpackage

// File: rtl/dircc_mem_port_master_if.sv
// Command, stream and Avalon-MM s2 signals of the memory-port initiator.
interface dircc_mem_port_master_if
    import dircc_mem_master_pkg::*;
#(
    parameter int ADDR_W = S2_ADDR_W,
    parameter int DATA_W = S2_DATA_W,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] address2;
    logic              chipselect2;
    logic              write2;
    logic [DATA_W-1:0] writedata2;
    logic [1:0]        byteenable2;
    logic              clken2;
    logic [DATA_W-1:0] readdata2;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, in_valid, in_data,
               out_ready, readdata2,
        output cmd_ready, in_ready, out_valid, out_data, address2, chipselect2,
               write2, writedata2, byteenable2, clken2, busy, done
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, in_valid, in_data,
               out_ready, readdata2,
        input  cmd_ready, in_ready, out_valid, out_data, address2, chipselect2,
               write2, writedata2, byteenable2, clken2, busy, done
    );

endinterface

// File: rtl/dircc_mem_rd_fifo.sv
// Small synchronous FIFO buffering read data returned from memory port s2.
module dircc_mem_rd_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/dircc_mem_port_master.sv
// Avalon-MM initiator for memory port s2: copies a write stream into memory or
// streams memory out through a credit-limited return FIFO, one command at a time.
module dircc_mem_port_master
    import dircc_mem_master_pkg::*;
#(
    parameter int ADDR_W     = S2_ADDR_W,
    parameter int DATA_W     = S2_DATA_W,
    parameter int LEN_W      = 8,
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input logic                     clk,
    input logic                     reset_n,
    dircc_mem_port_master_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              ready_q;
    logic              rd_vld_p1;
    logic              wr_beat;
    logic              rd_issue;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [31:0]       occ;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_WORDS - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    assign wr_beat = (state == ST_WR) && bus.in_valid;
    assign pop     = !fifo_empty && bus.out_ready;
    // Occupancy the FIFO will reach once the read now in flight lands, after this cycle's pop.
    assign occ      = 32'(fifo_count) + 32'(rd_vld_p1) - 32'(pop);
    assign rd_issue = (state == ST_RD) && (occ < 32'(FIFO_DEPTH));

    assign bus.cmd_ready   = ready_q;
    assign bus.in_ready    = (state == ST_WR);
    assign bus.chipselect2 = wr_beat || rd_issue;
    assign bus.write2      = wr_beat;
    assign bus.address2    = (wr_beat || rd_issue) ? cur_addr : '0;
    assign bus.writedata2  = wr_beat ? bus.in_data : '0;
    assign bus.byteenable2 = BE_ALL;
    assign bus.clken2      = 1'b1;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = fifo_empty ? '0 : fifo_head;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);

    // Stage p0 -> p1: a read issued now returns readdata2 next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            ready_q   <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_issue;
            unique case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        cur_addr  <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        if (bus.cmd_len == '0) state <= ST_DONE;
                        else if (bus.cmd_write) state <= ST_WR;
                        else state <= ST_RD;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (wr_beat) begin
                        cur_addr  <= next_addr(cur_addr);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) state <= ST_DONE;
                    end
                end
                ST_RD: begin
                    if (rd_issue) begin
                        cur_addr  <= next_addr(cur_addr);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!rd_vld_p1 && fifo_empty) state <= ST_DONE;
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dircc_mem_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rd_vld_p1),
        .push_data (bus.readdata2),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_dircc_mem_port_master.sv
// Bench for dircc_mem_port_master: memory model on s2, command-level reference
// model with a per-cycle compare process, and directed scenarios with literal checks.
module tb_dircc_mem_port_master;
    import dircc_mem_master_pkg::*;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int MW = 15000;
    localparam int FD = 2;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    dircc_mem_port_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    dircc_mem_port_master #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .LEN_W      (LW),
        .MEM_WORDS  (MW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind port s2: writes land on the edge, read data is valid the next cycle.
    logic [DW-1:0] ram     [MW];
    logic [DW-1:0] ref_mem [MW];
    always @(posedge clk) begin
        if (reset_n && bus.chipselect2) begin
            if (bus.write2) ram[bus.address2] <= bus.writedata2;
            else bus.readdata2 <= ram[bus.address2];
        end
    end

    // Output sink: always ready, or cycling through 1,0,0,1 in backpressure mode.
    logic [3:0] bp_pat  = 4'b1001;
    bit         bp_mode = 1'b0;
    int         bp_idx  = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.out_ready = bp_pat[bp_idx];
                bp_idx = (bp_idx + 1) % 4;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what the memory port and the stream must carry for each command.
    wr_t exp_wr[$];
    int  exp_rd[$];
    int  exp_out[$];
    int  wr_left = 0;
    bit  active  = 1'b0;
    int  issued  = 0;
    int  popped  = 0;

    int wr_addr_log[$];
    int wr_cyc_log[$];
    int out_data_log[$];
    int out_cyc_log[$];
    int acc_cyc   = 0;
    int done_cyc  = 0;
    int done_seen = 0;
    int done_mark = 0;
    int cs_cnt    = 0;
    int rd_cnt    = 0;

    always @(negedge clk) begin
        wr_t e;
        if (!reset_n) begin
            chk("rst_cs", int'(bus.chipselect2), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_busy", int'(bus.busy), 0);
        end else begin
            chk("byteenable", int'(bus.byteenable2), 3);
            chk("clken", int'(bus.clken2), 1);
            chk("busy", int'(bus.busy), int'(active));
            chk("in_ready", int'(bus.in_ready), int'(wr_left > 0));
            chk("wr_strobe", int'(bus.chipselect2 && bus.write2), int'(bus.in_valid && bus.in_ready));
            if (bus.cmd_ready) chk("cmd_ready_while_busy", int'(active), 0);
            if (bus.chipselect2) cs_cnt++;
            if (bus.chipselect2 && bus.write2) begin
                wr_addr_log.push_back(int'(bus.address2));
                wr_cyc_log.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", int'(bus.address2), -1);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", int'(bus.address2), e.addr);
                    chk("wr_data", int'(bus.writedata2), e.data);
                end
            end
            if (bus.chipselect2 && !bus.write2) begin
                issued++;
                rd_cnt++;
                if (exp_rd.size() == 0) chk("rd_unexpected", int'(bus.address2), -1);
                else chk("rd_addr", int'(bus.address2), exp_rd.pop_front());
            end
            if (bus.out_valid && bus.out_ready) begin
                popped++;
                out_data_log.push_back(int'(bus.out_data));
                out_cyc_log.push_back(cyc);
                if (exp_out.size() == 0) chk("out_unexpected", int'(bus.out_data), -1);
                else chk("out_data", int'(bus.out_data), exp_out.pop_front());
            end
            chk("reads_outstanding", int'((issued - popped) <= FD), 1);
            if (bus.done) begin
                chk("done_while_active", int'(active), 1);
                chk("done_work_left", exp_wr.size() + exp_rd.size() + exp_out.size(), 0);
                done_cyc = cyc;
                done_seen++;
                active = 1'b0;
            end
            if (bus.in_valid && bus.in_ready && wr_left > 0) wr_left--;
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc = cyc;
                active  = 1'b1;
                if (bus.cmd_write && bus.cmd_len != '0) wr_left = int'(bus.cmd_len);
            end
        end
    end

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_cyc_log.delete();
        out_data_log.delete();
        out_cyc_log.delete();
        cs_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, int'(bus.cmd_ready), 0);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_chipselect2"}, int'(bus.chipselect2), 0);
        chk({tag, "_write2"}, int'(bus.write2), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_address2"}, int'(bus.address2), 0);
        chk({tag, "_writedata2"}, int'(bus.writedata2), 0);
        chk({tag, "_out_data"}, int'(bus.out_data), 0);
    endtask

    task automatic issue_cmd(input logic wr, input int addr, input int len);
        int n = 0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = LW'(len);
        done_mark     = done_seen;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_seen == done_mark && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", int'(done_seen != done_mark), 1);
    endtask

    task automatic do_write(input int addr, input int len, input int base, input int gap);
        int a;
        int n;
        for (int i = 0; i < len; i++) begin
            a = (addr + i) % MW;
            exp_wr.push_back('{a, (base + i) & 16'hFFFF});
            ref_mem[a] = 16'(base + i);
        end
        issue_cmd(1'b1, addr, len);
        for (int i = 0; i < len; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(base + i);
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("in_ready_wait", int'(bus.in_ready), 1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (i < len - 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_done();
    endtask

    task automatic push_read(input int addr, input int len);
        int a;
        for (int i = 0; i < len; i++) begin
            a = (addr + i) % MW;
            exp_rd.push_back(a);
            exp_out.push_back(int'(ref_mem[a]));
        end
    endtask

    task automatic chk_lin(input string name, input int q[$], input int n, input int first);
        chk({name, "_count"}, q.size(), n);
        for (int i = 0; i < q.size() && i < n; i++) chk(name, q[i], first + i);
    endtask

    task automatic chk_step(input string name, input int q[$], input int step);
        for (int i = 1; i < q.size(); i++) chk(name, q[i] - q[i-1], step);
    endtask

    int bp_want [6] = '{32'hA001, 32'hA002, 32'hA003, 32'hA004, 32'hC3D7, 32'hC3D6};
    int wrap_addr [3] = '{14998, 14999, 0};
    int n_wait;
    int done_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MW; i++) begin
            ram[i]     = 16'(i) ^ 16'hC3C3;
            ref_mem[i] = 16'(i) ^ 16'hC3C3;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        reset_n       = 1'b0;
        #3;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Write 4 beats back to back, then read them out at full rate.
        clear_logs();
        do_write(32'h10, 4, 32'hA001, 0);
        chk_lin("t1_wr_addr", wr_addr_log, 4, 32'h10);
        chk_step("t1_wr_back_to_back", wr_cyc_log, 1);
        if (wr_cyc_log.size() == 4) chk("t1_done_after_last_beat", done_cyc - wr_cyc_log[3], 1);

        clear_logs();
        push_read(32'h10, 4);
        issue_cmd(1'b0, 32'h10, 4);
        wait_done();
        chk_lin("t1_rd_data", out_data_log, 4, 32'hA001);
        chk_step("t1_rd_consecutive", out_cyc_log, 1);
        // Accepted on the edge ending cycle acc; data registered two edges later shows in acc+3.
        if (out_cyc_log.size() > 0) chk("t1_rd_latency", out_cyc_log[0] - acc_cyc, 3);

        // Read 6 under a 1,0,0,1 sink.
        clear_logs();
        bp_idx  = 0;
        bp_mode = 1'b1;
        push_read(32'h10, 6);
        issue_cmd(1'b0, 32'h10, 6);
        wait_done();
        bp_mode = 1'b0;
        chk("t2_out_count", out_data_log.size(), 6);
        for (int i = 0; i < out_data_log.size() && i < 6; i++) chk("t2_out_data", out_data_log[i], bp_want[i]);
        chk("t2_reads_issued", rd_cnt, 6);

        // Address wrap at the top of memory.
        clear_logs();
        do_write(14998, 3, 32'hB001, 0);
        chk("t3_wr_count", wr_addr_log.size(), 3);
        for (int i = 0; i < wr_addr_log.size() && i < 3; i++) chk("t3_wr_addr", wr_addr_log[i], wrap_addr[i]);
        clear_logs();
        push_read(14998, 3);
        issue_cmd(1'b0, 14998, 3);
        wait_done();
        chk_lin("t3_rd_data", out_data_log, 3, 32'hB001);

        // Null command.
        clear_logs();
        issue_cmd(1'b0, 32'h50, 0);
        wait_done();
        chk("t4_done_latency", done_cyc - acc_cyc, 1);
        chk("t4_no_access", cs_cnt, 0);
        @(negedge clk);
        chk("t4_cmd_ready_again", int'(bus.cmd_ready), 1);

        // Input stream with 2-cycle gaps between beats.
        clear_logs();
        do_write(32'h200, 3, 32'hC001, 2);
        chk_lin("t5_wr_addr", wr_addr_log, 3, 32'h200);
        chk_step("t5_beat_spacing", wr_cyc_log, 3);
        chk("t5_cs_cycles", cs_cnt, 3);

        // Reset after 2 of 8 reads, then a normal write/read.
        clear_logs();
        push_read(32'h300, 8);
        issue_cmd(1'b0, 32'h300, 8);
        n_wait = 0;
        while (rd_cnt < 2 && n_wait < 50) begin
            @(posedge clk);
            n_wait++;
        end
        chk("t6_two_reads_before_reset", rd_cnt, 2);
        #2;
        reset_n = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        exp_out.delete();
        active      = 1'b0;
        wr_left     = 0;
        issued      = 0;
        popped      = 0;
        done_before = done_seen;
        #1;
        check_reset_outputs("mid");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_done_after_reset", done_seen, done_before);
        clear_logs();
        do_write(32'h300, 2, 32'hD001, 0);
        chk_lin("t6_wr_addr", wr_addr_log, 2, 32'h300);
        clear_logs();
        push_read(32'h300, 2);
        issue_cmd(1'b0, 32'h300, 2);
        wait_done();
        chk_lin("t6_rd_data", out_data_log, 2, 32'hD001);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
